// File: rtl/adc_sar_pkg.sv
// rtl/adc_sar_pkg.sv - shared types and constants for the SAR ADC controller
package adc_sar_pkg;

  localparam int SAR_RESOLUTION = 12;
  localparam logic [11:0] SAR_MIDSCALE = 12'h800;
  localparam int CNT_W = 8;

  // Field split of the DAC word as seen by the capacitor-matrix decoder
  localparam int ROW_MSB    = 11;
  localparam int ROW_LSB    = 8;
  localparam int COL_MSB    = 7;
  localparam int COL_LSB    = 3;
  localparam int BINCAP_MSB = 2;
  localparam int BINCAP_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SAMPLE  = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } sar_state_e;

endpackage

// File: rtl/adc_wait_counter.sv
// rtl/adc_wait_counter.sv - loadable saturating down-counter with zero flag
module adc_wait_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/adc_sar_control.sv
// rtl/adc_sar_control.sv - successive-approximation controller, MSB-first trial DAC word
module adc_sar_control
  import adc_sar_pkg::*;
#(
  parameter int RESOLUTION    = SAR_RESOLUTION,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int COMP_TIMEOUT  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_conv,
  input  logic                  comp_result,
  input  logic                  comp_ready,
  output logic                  comp_trig_out,
  output logic                  sample_out,
  output logic [RESOLUTION-1:0] dac_data_out,
  output logic [RESOLUTION-1:0] result_out,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  comp_timeout_err
);

  localparam int IDX_W = $clog2(RESOLUTION);
  localparam logic [RESOLUTION-1:0] MIDSCALE = {1'b1, {(RESOLUTION-1){1'b0}}};

  localparam logic [2:0] IDLE    = ST_IDLE;
  localparam logic [2:0] SAMPLE  = ST_SAMPLE;
  localparam logic [2:0] SETTLE  = ST_SETTLE;
  localparam logic [2:0] COMPARE = ST_COMPARE;
  localparam logic [2:0] DONE    = ST_DONE;

  logic [2:0]            state;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_m1;
  logic [RESOLUTION-1:0] sar;
  logic                  cnt_load;
  logic [CNT_W-1:0]      cnt_value;
  logic                  cnt_zero;
  logic                  resolve;
  logic                  bit_val;

  adc_wait_counter #(.WIDTH(CNT_W)) u_wait (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .load_value (cnt_value),
    .zero       (cnt_zero)
  );

  // The trigger cycle is the COMPARE entry cycle; a strobe there is stale.
  assign resolve = (state == COMPARE) && !comp_trig_out && (comp_ready || cnt_zero);
  assign bit_val = comp_ready & comp_result;
  assign idx_m1  = idx - 1'b1;

  always_comb begin
    cnt_load  = 1'b0;
    cnt_value = '0;
    case (state)
      IDLE: if (start_conv) begin
        cnt_load  = 1'b1;
        cnt_value = CNT_W'(SAMPLE_CYCLES - 1);
      end
      SAMPLE: if (cnt_zero) begin
        cnt_load  = 1'b1;
        cnt_value = CNT_W'(SETTLE_CYCLES - 1);
      end
      // Loaded with the full timeout so it reaches zero COMP_TIMEOUT cycles after the trigger
      SETTLE: if (cnt_zero) begin
        cnt_load  = 1'b1;
        cnt_value = CNT_W'(COMP_TIMEOUT);
      end
      COMPARE: if (resolve && idx != '0) begin
        cnt_load  = 1'b1;
        cnt_value = CNT_W'(SETTLE_CYCLES - 1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      idx              <= '0;
      sar              <= '0;
      result_out       <= '0;
      comp_trig_out    <= 1'b0;
      comp_timeout_err <= 1'b0;
    end else begin
      comp_trig_out <= 1'b0;
      case (state)
        IDLE: if (start_conv) begin
          state            <= SAMPLE;
          sar              <= MIDSCALE;
          idx              <= IDX_W'(RESOLUTION - 1);
          comp_timeout_err <= 1'b0;
        end
        SAMPLE: if (cnt_zero) state <= SETTLE;
        SETTLE: if (cnt_zero) begin
          state         <= COMPARE;
          comp_trig_out <= 1'b1;
        end
        COMPARE: if (resolve) begin
          sar[idx] <= bit_val;
          if (!comp_ready) comp_timeout_err <= 1'b1;
          if (idx != '0) begin
            sar[idx_m1] <= 1'b1;
            idx         <= idx_m1;
            state       <= SETTLE;
          end else begin
            result_out <= {sar[RESOLUTION-1:1], bit_val};
            state      <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign sample_out   = (state == SAMPLE);
  assign busy         = (state != IDLE);
  assign result_valid = (state == DONE);
  assign dac_data_out = sar;

endmodule

// File: tb/tb_adc_sar_control.sv
// tb/tb_adc_sar_control.sv - directed bench with per-cycle conversion timeline model
module tb_adc_sar_control;
  import adc_sar_pkg::*;

  localparam int NSAMP   = 4;
  localparam int NSETTLE = 1;
  localparam int TMO     = 16;

  logic        clk = 1'b0;
  logic        rst, start_conv, comp_result, comp_ready;
  logic        comp_trig_out, sample_out, result_valid, busy, comp_timeout_err;
  logic [11:0] dac_data_out, result_out;

  adc_sar_control dut (
    .clk              (clk),
    .rst              (rst),
    .start_conv       (start_conv),
    .comp_result      (comp_result),
    .comp_ready       (comp_ready),
    .comp_trig_out    (comp_trig_out),
    .sample_out       (sample_out),
    .dac_data_out     (dac_data_out),
    .result_out       (result_out),
    .result_valid     (result_valid),
    .busy             (busy),
    .comp_timeout_err (comp_timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic busy, sample, trig, valid, err;
    logic [11:0] dac, res;
  } exp_t;
  typedef struct packed {
    logic start, ready, result, rst;
  } stim_t;

  exp_t  exp_q[$];
  stim_t stim_q[$];
  logic [11:0] trig_dacs[$];
  logic [11:0] m_dac = '0, m_res = '0;
  logic        m_err = 1'b0;
  int errors = 0, checks = 0;
  int v_cnt, v_cyc, err_cyc, busy_cnt;

  task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, want);
    end
  endtask

  task automatic add(input logic b, s, t, v, e, input logic [11:0] d, r);
    exp_t x;
    x = '{busy: b, sample: s, trig: t, valid: v, err: e, dac: d, res: r};
    exp_q.push_back(x);
    stim_q.push_back('0);
  endtask

  // Conversion timeline from the SAR rules; lat = cycles from trigger to the
  // accepted comp_ready (0 = comparator never answers).
  task automatic build(input logic [11:0] vin, input int lat, input bit noise,
                       input bit extra, input int rst_cyc);
    logic [11:0] word, trial;
    logic e;
    int w, last, done_i;
    bit ok;
    exp_q.delete();
    stim_q.delete();
    add(0, 0, 0, 0, m_err, m_dac, m_res);
    stim_q[0].start = 1'b1;
    for (int s = 0; s < NSAMP; s++) begin
      add(1, 1, 0, 0, 0, SAR_MIDSCALE, m_res);
      if (noise) begin
        last = stim_q.size() - 1;
        stim_q[last].ready  = 1'b1;
        stim_q[last].result = 1'b1;
      end
    end
    e = 1'b0;
    word = '0;
    ok = (lat >= 1) && (lat <= TMO);
    w  = ok ? lat : TMO;
    for (int i = 11; i >= 0; i--) begin
      trial = word | (12'h1 << i);
      for (int s = 0; s < NSETTLE; s++) add(1, 0, 0, 0, e, trial, m_res);
      add(1, 0, 1, 0, e, trial, m_res);
      if (noise) begin
        last = stim_q.size() - 1;
        stim_q[last].ready  = 1'b1;
        stim_q[last].result = !(vin >= trial);
      end
      for (int k = 1; k <= w; k++) begin
        add(1, 0, 0, 0, e, trial, m_res);
        if (ok && k == lat) begin
          last = stim_q.size() - 1;
          stim_q[last].ready  = 1'b1;
          stim_q[last].result = (vin >= trial);
        end
      end
      if (ok && vin >= trial) word = trial;
      if (!ok) e = 1'b1;
    end
    add(1, 0, 0, 1, e, word, word);
    done_i = exp_q.size() - 1;
    add(0, 0, 0, 0, e, word, word);
    m_dac = word;
    m_res = word;
    m_err = e;
    if (extra) begin
      stim_q[10].start     = 1'b1;
      stim_q[done_i].start = 1'b1;
    end
    if (rst_cyc >= 0) begin
      while (exp_q.size() > rst_cyc + 1) begin
        void'(exp_q.pop_back());
        void'(stim_q.pop_back());
      end
      stim_q[rst_cyc].rst = 1'b1;
      for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 12'h000, 12'h000);
      m_dac = '0;
      m_res = '0;
      m_err = 1'b0;
    end
  endtask

  task automatic run();
    v_cnt = 0; v_cyc = -1; err_cyc = -1; busy_cnt = 0;
    trig_dacs.delete();
    for (int c = 0; c < exp_q.size(); c++) begin
      start_conv  = stim_q[c].start;
      comp_ready  = stim_q[c].ready;
      comp_result = stim_q[c].result;
      rst         = stim_q[c].rst;
      @(negedge clk);
      check("busy",   c, 32'(busy),             32'(exp_q[c].busy));
      check("sample", c, 32'(sample_out),       32'(exp_q[c].sample));
      check("trig",   c, 32'(comp_trig_out),    32'(exp_q[c].trig));
      check("valid",  c, 32'(result_valid),     32'(exp_q[c].valid));
      check("err",    c, 32'(comp_timeout_err), 32'(exp_q[c].err));
      check("dac",    c, 32'(dac_data_out),     32'(exp_q[c].dac));
      check("result", c, 32'(result_out),       32'(exp_q[c].res));
      if (result_valid === 1'b1) begin v_cnt++; v_cyc = c; end
      if (busy === 1'b1) busy_cnt++;
      if (comp_timeout_err === 1'b1 && err_cyc < 0) err_cyc = c;
      if (comp_trig_out === 1'b1) trig_dacs.push_back(dac_data_out);
      @(posedge clk);
      #1;
    end
    start_conv = 0; comp_ready = 0; comp_result = 0; rst = 0;
  endtask

  initial begin
    rst = 1; start_conv = 0; comp_ready = 0; comp_result = 0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_busy",   -1, 32'(busy),             0);
    check("rst_dac",    -1, 32'(dac_data_out),     0);
    check("rst_result", -1, 32'(result_out),       0);
    check("rst_err",    -1, 32'(comp_timeout_err), 0);
    check("rst_valid",  -1, 32'(result_valid),     0);
    @(posedge clk);
    #1;
    rst = 0;

    build(12'hA5C, 1, 0, 0, -1); run();
    check("a5c_result",  -1, 32'(result_out), 32'h0A5C);
    check("a5c_vcycle",  -1, v_cyc, 41);
    check("a5c_vcount",  -1, v_cnt, 1);
    check("a5c_ntrig",   -1, trig_dacs.size(), 12);
    if (trig_dacs.size() >= 5) begin
      check("a5c_trial0", -1, 32'(trig_dacs[0]), 32'h800);
      check("a5c_trial1", -1, 32'(trig_dacs[1]), 32'hC00);
      check("a5c_trial2", -1, 32'(trig_dacs[2]), 32'hA00);
      check("a5c_trial3", -1, 32'(trig_dacs[3]), 32'hB00);
      check("a5c_trial4", -1, 32'(trig_dacs[4]), 32'hA80);
    end

    build(12'hFFF, 1, 0, 0, -1); run();
    check("fff_result", -1, 32'(result_out), 32'hFFF);
    check("fff_busy",   -1, busy_cnt, 41);

    build(12'h000, 1, 0, 0, -1); run();
    check("zero_result", -1, 32'(result_out), 32'h000);

    build(12'hFFF, 0, 0, 0, -1); run();
    check("tmo_result",  -1, 32'(result_out), 32'h000);
    check("tmo_err",     -1, 32'(comp_timeout_err), 1);
    check("tmo_errcyc",  -1, err_cyc, 23);
    check("tmo_vcycle",  -1, v_cyc, 221);

    build(12'hA5C, 1, 0, 1, -1); run();
    check("ign_vcount", -1, v_cnt, 1);
    check("ign_result", -1, 32'(result_out), 32'hA5C);

    build(12'h3C7, 3, 1, 0, -1); run();
    check("late_result", -1, 32'(result_out), 32'h3C7);

    build(12'h5A5, 1, 0, 0, 20); run();
    check("rst_vcount",   -1, v_cnt, 0);
    check("rst_midconv",  -1, 32'(result_out), 0);

    build(12'h123, 2, 0, 0, -1); run();
    check("post_result", -1, 32'(result_out), 32'h123);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
